// File: rtl/main_mem_pkg.sv
// main_mem_pkg: shared state encoding, request-direction codes and sizing helper for main_mem_model.
package main_mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, BURST, WCOMMIT} mem_state_t;
  localparam logic MRW_READ  = 1'b1;
  localparam logic MRW_WRITE = 1'b0;
  function automatic int off_w(input int lw);
    return (lw > 1) ? $clog2(lw) : 1;
  endfunction
endpackage

// File: rtl/mem_cycle_ctr.sv
// mem_cycle_ctr: loadable down-counter that saturates at zero and flags it.
module mem_cycle_ctr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);
  logic [W-1:0] count_q, count_d;
  always_comb count_d = load ? load_val : (count_q != '0) ? count_q - W'(1) : count_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) count_q <= '0;
    else count_q <= count_d;
  assign count = count_q;
  assign zero  = (count_q == '0);
endmodule

// File: rtl/main_mem_model.sv
// main_mem_model: fixed-latency main memory serving single-word writes and aligned line-fill bursts.
module main_mem_model
  import main_mem_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int LINE_WORDS = 4,
  parameter int LATENCY    = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            MStrobe,
  input  logic                            MRW,
  input  logic [ADDR_W-1:0]               MAddr,
  input  logic [DATA_W-1:0]               MWData,
  output logic [DATA_W-1:0]               MRData,
  output logic                            MDValid,
  output logic [off_w(LINE_WORDS)-1:0]    MWordIdx,
  output logic                            MDone,
  output logic                            MBusy,
  output logic                            MErr
);
  localparam int OW = off_w(LINE_WORDS);
  localparam int CW = $clog2(LATENCY + LINE_WORDS);
  mem_state_t state_q, state_d;
  logic rw_q, rw_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d, rd_addr;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic ctr_load, ctr_zero, idle, accept, rd_en, fill_start;
  logic [CW-1:0] ctr_val, ctr_cnt;
  logic [OW-1:0] beat, nxt_beat;
  assign idle       = (state_q == IDLE);
  assign accept     = idle && MStrobe;
  assign fill_start = (state_q == WAIT) && ctr_zero && (rw_q == MRW_READ);
  // The one counter times the WAIT phase, then is reloaded to count down the burst beats.
  assign ctr_load = accept || fill_start;
  assign ctr_val  = idle ? CW'(LATENCY - 1) : CW'(LINE_WORDS - 1);
  mem_cycle_ctr #(.W(CW)) u_ctr (
    .clk(clk), .reset_n(reset_n), .load(ctr_load), .load_val(ctr_val),
    .count(ctr_cnt), .zero(ctr_zero)
  );
  assign beat     = OW'(LINE_WORDS - 1 - int'(ctr_cnt));
  assign nxt_beat = beat + OW'(1);
  // Reads are prefetched one cycle ahead so every beat comes straight from a register.
  assign rd_en   = fill_start || ((state_q == BURST) && !ctr_zero);
  assign rd_addr = (state_q == WAIT) ? addr_q : (addr_q | ADDR_W'(nxt_beat));
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = MStrobe ? WAIT : IDLE;
      WAIT:    state_d = !ctr_zero ? WAIT : (rw_q == MRW_READ) ? BURST : WCOMMIT;
      BURST:   state_d = ctr_zero ? IDLE : BURST;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    rw_d    = accept ? MRW : rw_q;
    addr_d  = !accept ? addr_q : (MRW == MRW_READ) ? (MAddr & ~ADDR_W'(LINE_WORDS - 1)) : MAddr;
    wdata_d = accept ? MWData : wdata_q;
    rdata_d = rd_en ? mem[rd_addr] : rdata_q;
    err_d   = MStrobe && !idle;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      rw_q    <= MRW_WRITE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  always_ff @(posedge clk)
    if (state_q == WCOMMIT) mem[addr_q] <= wdata_q;
  assign MBusy    = !idle;
  assign MDValid  = (state_q == BURST);
  assign MWordIdx = MDValid ? beat : '0;
  assign MDone    = (MDValid && ctr_zero) || (state_q == WCOMMIT);
  assign MRData   = rdata_q;
  assign MErr     = err_q;
endmodule

// File: tb/tb_main_mem_model.sv
// tb_main_mem_model: randomized checks of main_mem_model against a timeline-and-array reference model.
module tb_main_mem_model;
  localparam int LAT = 4, LW = 4, AW = 10, DW = 32, MAXC = 20;
  logic clk = 1'b0, reset_n = 1'b0, MStrobe = 1'b0, MRW = 1'b0;
  logic [AW-1:0] MAddr = '0;
  logic [DW-1:0] MWData = '0;
  logic [DW-1:0] MRData;
  logic MDValid, MDone, MBusy, MErr;
  logic [1:0] MWordIdx;
  int checks = 0, errors = 0;
  logic [DW-1:0] model [1<<AW];
  bit known [1<<AW];
  logic ob_busy [MAXC+1], ob_dv [MAXC+1], ob_done [MAXC+1], ob_err [MAXC+1];
  logic [1:0] ob_idx [MAXC+1];
  logic [DW-1:0] ob_d [MAXC+1];
  int done_cyc, n_done;
  logic gap_busy;

  always #5 clk = ~clk;

  main_mem_model #(.DATA_W(DW), .ADDR_W(AW), .LINE_WORDS(LW), .LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .MStrobe(MStrobe), .MRW(MRW), .MAddr(MAddr),
    .MWData(MWData), .MRData(MRData), .MDValid(MDValid), .MWordIdx(MWordIdx),
    .MDone(MDone), .MBusy(MBusy), .MErr(MErr)
  );

  // Issues one request in the current cycle (cycle 0) and records outputs for cycles 1..n.
  task automatic run_req(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int err_at, input int rst_at);
    MStrobe = 1'b1; MRW = rw; MAddr = a; MWData = d;
    done_cyc = 0; n_done = 0;
    for (int n = 0; n <= MAXC; n++) begin
      ob_busy[n] = 0; ob_dv[n] = 0; ob_done[n] = 0; ob_err[n] = 0; ob_idx[n] = 0; ob_d[n] = 0;
    end
    for (int n = 1; n <= MAXC; n++) begin
      @(posedge clk); #1;
      MStrobe = (n == err_at); MRW = 1'($urandom); MAddr = AW'($urandom); MWData = $urandom;
      if (rst_at != 0 && n == rst_at) begin reset_n = 1'b0; #1; end
      if (rst_at != 0 && n == rst_at + 1) reset_n = 1'b1;
      ob_busy[n] = MBusy; ob_dv[n] = MDValid; ob_done[n] = MDone; ob_err[n] = MErr;
      ob_idx[n] = MWordIdx; ob_d[n] = MRData;
      if (MDone === 1'b1) begin n_done++; if (done_cyc == 0) done_cyc = n; end
      if (MDone === 1'b1 && rst_at == 0) break;
    end
    MStrobe = 1'b0;
    if (rw == 1'b0 && rst_at == 0) begin model[a] = d; known[a] = 1; end
    @(posedge clk); #1;
    gap_busy = MBusy;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (MBusy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", MBusy); end
    checks++; if (MDValid !== 1'b0) begin errors++; $display("FAIL rst_dvalid: got %b exp 0", MDValid); end
    checks++; if (MDone !== 1'b0) begin errors++; $display("FAIL rst_done: got %b exp 0", MDone); end
    checks++; if (MErr !== 1'b0) begin errors++; $display("FAIL rst_err: got %b exp 0", MErr); end
    checks++; if (MWordIdx !== 2'd0) begin errors++; $display("FAIL rst_idx: got %0d exp 0", MWordIdx); end
    checks++; if (MRData !== '0) begin errors++; $display("FAIL rst_rdata: got %h exp 0", MRData); end
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (MBusy !== 1'b0 || MDone !== 1'b0) begin errors++; $display("FAIL post_rst_idle: got busy=%b done=%b exp 0 0", MBusy, MDone); end
  endtask

  task automatic test_write_read;
    logic bad;
    run_req(1'b0, 10'h012, 32'hDEADBEEF, 0, 0);
    checks++; if (done_cyc != LAT + 1) begin errors++; $display("FAIL wr_done_cyc: got %0d exp %0d", done_cyc, LAT + 1); end
    bad = 0;
    for (int n = 1; n <= LAT + 1; n++) if (ob_busy[n] !== 1'b1 || ob_dv[n] !== 1'b0) bad = 1;
    checks++; if (bad) begin errors++; $display("FAIL wr_busy_window: got bad=%b exp 0", bad); end
    checks++; if (gap_busy !== 1'b0) begin errors++; $display("FAIL wr_idle_after: got %b exp 0", gap_busy); end
    run_req(1'b1, 10'h013, $urandom, 0, 0);
    checks++; if (done_cyc != LAT + LW || n_done != 1) begin errors++; $display("FAIL rd_done: got cyc=%0d n=%0d exp cyc=%0d n=1", done_cyc, n_done, LAT + LW); end
    bad = 0;
    for (int n = 1; n <= LAT; n++) if (ob_dv[n] !== 1'b0 || ob_busy[n] !== 1'b1) bad = 1;
    checks++; if (bad) begin errors++; $display("FAIL rd_wait_window: got bad=%b exp 0", bad); end
    for (int k = 0; k < LW; k++) begin
      checks++; if (ob_dv[LAT+1+k] !== 1'b1 || ob_idx[LAT+1+k] !== 2'(k))
        begin errors++; $display("FAIL rd_beat%0d: got dv=%b idx=%0d exp dv=1 idx=%0d", k, ob_dv[LAT+1+k], ob_idx[LAT+1+k], k); end
      if (known[10'h010 + k]) begin
        checks++; if (ob_d[LAT+1+k] !== model[10'h010 + k]) begin errors++; $display("FAIL rd_data%0d: got %h exp %h", k, ob_d[LAT+1+k], model[10'h010 + k]); end
      end
    end
    checks++; if (ob_d[LAT+3] !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_word2: got %h exp deadbeef", ob_d[LAT+3]); end
  endtask

  task automatic test_line_fill;
    logic [AW-1:0] base, a;
    for (int k = 0; k < LW; k++) run_req(1'b0, 10'h020 + AW'(k), 32'h100 + k, 0, 0);
    run_req(1'b1, 10'h022, $urandom, 0, 0);
    for (int k = 0; k < LW; k++) begin
      checks++; if (ob_d[LAT+1+k] !== 32'h100 + k || ob_idx[LAT+1+k] !== 2'(k))
        begin errors++; $display("FAIL fill_beat%0d: got data=%h idx=%0d exp data=%h idx=%0d", k, ob_d[LAT+1+k], ob_idx[LAT+1+k], 32'h100 + k, k); end
    end
    repeat (5) begin
      base = AW'($urandom) & ~AW'(LW - 1);
      for (int k = 0; k < LW; k++) run_req(1'b0, base + AW'(k), $urandom, 0, 0);
      a = base | AW'($urandom_range(LW - 1));
      run_req(1'b1, a, $urandom, 0, 0);
      checks++; if (done_cyc != LAT + LW) begin errors++; $display("FAIL rand_done_cyc: got %0d exp %0d", done_cyc, LAT + LW); end
      for (int k = 0; k < LW; k++) begin
        checks++; if (ob_dv[LAT+1+k] !== 1'b1 || ob_d[LAT+1+k] !== model[base + AW'(k)])
          begin errors++; $display("FAIL rand_beat%0d @%h: got dv=%b data=%h exp dv=1 data=%h", k, base, ob_dv[LAT+1+k], ob_d[LAT+1+k], model[base + AW'(k)]); end
      end
    end
  endtask

  task automatic test_busy_strobe;
    logic [DW-1:0] v;
    int errs;
    logic bad;
    v = $urandom;
    run_req(1'b0, 10'h040, v, 2, 0);
    errs = 0;
    for (int n = 1; n <= MAXC; n++) if (ob_err[n] === 1'b1) errs++;
    checks++; if (ob_err[3] !== 1'b1 || errs != 1) begin errors++; $display("FAIL busy_err_pulse: got err3=%b count=%0d exp 1 1", ob_err[3], errs); end
    checks++; if (done_cyc != LAT + 1 || n_done != 1) begin errors++; $display("FAIL busy_orig_done: got cyc=%0d n=%0d exp %0d 1", done_cyc, n_done, LAT + 1); end
    bad = 0;
    for (int n = 0; n < 2 * LAT; n++) begin
      if (MBusy !== 1'b0) bad = 1;
      @(posedge clk); #1;
    end
    checks++; if (bad) begin errors++; $display("FAIL busy_no_second_txn: got bad=%b exp 0", bad); end
    run_req(1'b1, 10'h040, $urandom, 0, 0);
    checks++; if (ob_d[LAT+1] !== v) begin errors++; $display("FAIL busy_orig_data: got %h exp %h", ob_d[LAT+1], v); end
  endtask

  task automatic test_back_to_back;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int off;
    a = AW'($urandom); d = $urandom; off = int'(a) % LW;
    run_req(1'b0, a, d, 0, 0);
    checks++; if (gap_busy !== 1'b0) begin errors++; $display("FAIL b2b_gap: got busy=%b exp 0", gap_busy); end
    run_req(1'b1, a, $urandom, 0, 0);
    checks++; if (ob_busy[1] !== 1'b1 || done_cyc != LAT + LW) begin errors++; $display("FAIL b2b_accept: got busy1=%b cyc=%0d exp 1 %0d", ob_busy[1], done_cyc, LAT + LW); end
    checks++; if (ob_d[LAT+1+off] !== d) begin errors++; $display("FAIL b2b_raw_data: got %h exp %h", ob_d[LAT+1+off], d); end
  endtask

  task automatic test_reset_mid;
    logic bad;
    logic [DW-1:0] a_val;
    run_req(1'b1, 10'h021, $urandom, 0, LAT + 3);
    checks++; if (ob_dv[LAT+2] !== 1'b1 || ob_idx[LAT+2] !== 2'd1 || ob_d[LAT+2] !== model[10'h021])
      begin errors++; $display("FAIL rstmid_beat1: got dv=%b idx=%0d data=%h exp 1 1 %h", ob_dv[LAT+2], ob_idx[LAT+2], ob_d[LAT+2], model[10'h021]); end
    bad = 0;
    for (int n = LAT + 3; n <= MAXC; n++) if (ob_busy[n] !== 1'b0 || ob_dv[n] !== 1'b0 || ob_done[n] !== 1'b0 || ob_idx[n] !== 2'd0) bad = 1;
    checks++; if (bad || n_done != 0) begin errors++; $display("FAIL rstmid_clear: got bad=%b dones=%0d exp 0 0", bad, n_done); end
    checks++; if (ob_d[LAT+3] !== '0) begin errors++; $display("FAIL rstmid_rdata: got %h exp 0", ob_d[LAT+3]); end
    a_val = $urandom;
    run_req(1'b0, 10'h030, a_val, 0, 0);
    run_req(1'b0, 10'h030, ~a_val, 0, 2);
    checks++; if (n_done != 0) begin errors++; $display("FAIL rstwr_done: got %0d exp 0", n_done); end
    run_req(1'b1, 10'h030, $urandom, 0, 0);
    checks++; if (ob_d[LAT+1] !== model[10'h030]) begin errors++; $display("FAIL rstwr_discard: got %h exp %h", ob_d[LAT+1], model[10'h030]); end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got no finish exp finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write_read();
    test_line_fill();
    test_busy_strobe();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
